// File: rtl/uart_alu_interface.sv
// Frame sequencer between the UART FIFOs and the ALU: pops A, B and opcode, latches the
// ALU result, pushes it to the tx FIFO and shows it on the LEDs. Optional: UART_ALU_TIMEOUT_EN.
module uart_alu_interface #(
    parameter int N_BIT  = 8,
    parameter int N_OP   = 6,
    parameter int TO_CYC = 50000000,
    parameter int TO_BIT = 26
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             rx_empty,
    input  logic [N_BIT-1:0] r_data,
    output logic             rd_uart,
    input  logic             tx_full,
    output logic             wr_uart,
    output logic [N_BIT-1:0] w_data,
    output logic [N_BIT-1:0] alu_a,
    output logic [N_BIT-1:0] alu_b,
    output logic [N_OP-1:0]  alu_op,
    input  logic [N_BIT-1:0] alu_result,
    output logic [N_BIT-1:0] leds,
    output logic             busy,
    output logic             err,
    output logic [2:0]       dbg_state
);

    // Handshake: rd_uart pops the rx head in the cycle it is high and is only raised
    // while rx_empty=0; wr_uart pushes w_data in the cycle it is high and is only raised
    // while tx_full=0. The two strobes live in disjoint states and never overlap.
    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } state_t;

    localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TO_CYC - 1);

    state_t state;
    state_t state_next;
    logic   in_get;
    logic   wait_mid;
    logic   timeout;

    assign in_get   = (state == GET_A) || (state == GET_B) || (state == GET_OP);
    assign wait_mid = ((state == GET_B) || (state == GET_OP)) && rx_empty;

`ifdef UART_ALU_TIMEOUT_EN
    logic [TO_BIT-1:0] to_cnt;

    // Measures the silence since the last popped byte of the current frame.
    always_ff @(posedge CLK) begin
        if (RESET || rd_uart || (state == GET_A)) begin
            to_cnt <= '0;
        end else if (wait_mid) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout = wait_mid && (to_cnt == TO_LAST);
`else
    // The timeout parameters are inert in this build.
    logic [TO_BIT-1:0] unused_to_last;
    assign unused_to_last = TO_LAST;
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= GET_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            GET_A: begin
                if (!rx_empty) state_next = GET_B;
            end
            GET_B: begin
                if (!rx_empty)    state_next = GET_OP;
                else if (timeout) state_next = GET_A;
            end
            GET_OP: begin
                if (!rx_empty)    state_next = EXEC;
                else if (timeout) state_next = GET_A;
            end
            EXEC: begin
                state_next = SEND;
            end
            SEND: begin
                if (!tx_full) state_next = GET_A;
            end
            default: begin
                state_next = GET_A;
            end
        endcase
    end

    // Strobes are masked during reset so every output reads 0 while RESET is high.
    always_comb begin
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        busy    = 1'b0;
        err     = 1'b0;
        if (!RESET) begin
            rd_uart = in_get && !rx_empty;
            wr_uart = (state == SEND) && !tx_full;
            busy    = (state != GET_A);
            err     = timeout;
        end
    end

    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            w_data <= '0;
            leds   <= '0;
        end else begin
            if (rd_uart) begin
                case (state)
                    GET_A:   alu_a  <= r_data;
                    GET_B:   alu_b  <= r_data;
                    GET_OP:  alu_op <= r_data[N_OP-1:0];
                    default: ;
                endcase
            end
            if (state == EXEC) begin
                w_data <= alu_result;
                leds   <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: queue-based rx FIFO, an ALU stand-in, and a scoreboard
// of expected tx bytes computed per frame. Timeout scenarios need UART_ALU_TIMEOUT_EN.
module tb_uart_alu_interface;

    localparam int N_BIT  = 8;
    localparam int N_OP   = 6;
    localparam int TO_CYC = 16;
    localparam int TO_BIT = 5;

    logic             CLK;
    logic             RESET;
    logic             rx_empty;
    logic [N_BIT-1:0] r_data;
    logic             rd_uart;
    logic             tx_full;
    logic             wr_uart;
    logic [N_BIT-1:0] w_data;
    logic [N_BIT-1:0] alu_a;
    logic [N_BIT-1:0] alu_b;
    logic [N_OP-1:0]  alu_op;
    logic [N_BIT-1:0] alu_result;
    logic [N_BIT-1:0] leds;
    logic             busy;
    logic             err;
    logic [2:0]       dbg_state;

    int          checks    = 0;
    int          failures  = 0;
    int          cycle     = 0;
    int          n_push    = 0;
    bit          rand_tx   = 1'b0;
    bit          err_allowed = 1'b0;
    logic [63:0] pop_mask  = '0;
    logic [63:0] push_mask = '0;
    logic [63:0] err_mask  = '0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];

    uart_alu_interface #(
        .N_BIT (N_BIT),
        .N_OP  (N_OP),
        .TO_CYC(TO_CYC),
        .TO_BIT(TO_BIT)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_result(alu_result),
        .leds      (leds),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- ALU stand-in and reference ----------------
    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    // ---------------- driver tasks ----------------
    task automatic drive_rx();
        rx_empty = (rx_q.size() == 0);
        r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    endtask

    task automatic clear_logs();
        pop_mask  = '0;
        push_mask = '0;
        err_mask  = '0;
        n_push    = 0;
        cycle     = 0;
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        rx_q.push_back(a);
        rx_q.push_back(b);
        rx_q.push_back(op);
        exp_q.push_back(alu_model(a, b, op[5:0]));
        drive_rx();
        #1;
    endtask

    task automatic push_byte(input logic [7:0] v);
        rx_q.push_back(v);
        drive_rx();
        #1;
    endtask

    // One clock cycle: observe settled outputs, clock, then apply the FIFO side effects.
    task automatic tick();
        logic       pop;
        logic       push;
        logic [7:0] exp;
        pop  = rd_uart;
        push = wr_uart;
        checks++;
        if ((rd_uart && rx_empty) || (wr_uart && tx_full) || (rd_uart && wr_uart)) begin
            failures++;
            $display("FAIL strobe_protocol cycle=%0d rd=%b rx_empty=%b wr=%b tx_full=%b (need no pop on empty, no push on full, no overlap)",
                     cycle, rd_uart, rx_empty, wr_uart, tx_full);
        end
        checks++;
        if (err && !err_allowed) begin
            failures++;
            $display("FAIL err_spurious cycle=%0d got err=1 expected 0", cycle);
        end
        if (cycle < 64) begin
            if (pop)  pop_mask[cycle]  = 1'b1;
            if (push) push_mask[cycle] = 1'b1;
            if (err)  err_mask[cycle]  = 1'b1;
        end
        if (push) begin
            n_push++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL tx_unexpected cycle=%0d got w_data=%h expected no push", cycle, w_data);
            end else begin
                exp = exp_q.pop_front();
                if (w_data !== exp) begin
                    failures++;
                    $display("FAIL tx_byte cycle=%0d got %h expected %h", cycle, w_data, exp);
                end
            end
        end
        @(posedge CLK);
        #1;
        if (pop && (rx_q.size() > 0)) void'(rx_q.pop_front());
        if (rand_tx) tx_full = ($urandom_range(0, 2) == 0);
        drive_rx();
        cycle++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (((exp_q.size() != 0) || (rx_q.size() != 0) || busy) && (n < budget)) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain_timeout got %0d results pending after %0d cycles expected 0",
                     exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET = 1'b1;
        #1;
        tick();
        tick();
        checks++;
        if ({rd_uart, wr_uart, busy, err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes got rd/wr/busy/err=%b expected 0000", {rd_uart, wr_uart, busy, err});
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== '0) begin
            failures++;
            $display("FAIL reset_alu_regs got a=%h b=%h op=%h expected 0", alu_a, alu_b, alu_op);
        end
        checks++;
        if ({w_data, leds} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_tx_leds got w_data=%h leds=%h expected 00", w_data, leds);
        end
        RESET = 1'b0;
        #1;
        tick();
    endtask

    task automatic test_single_frame();
        clear_logs();
        push_frame(8'h05, 8'h03, 8'h20);
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_mid_frame got %b expected 1", busy);
        end
        run(7);
        checks++;
        if ((pop_mask !== 64'h7) || (push_mask !== 64'h10)) begin
            failures++;
            $display("FAIL frame_timing got pops=%h pushes=%h expected 7 10", pop_mask, push_mask);
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== {8'h05, 8'h03, 6'h20}) begin
            failures++;
            $display("FAIL frame_operands got a=%h b=%h op=%h expected 05 03 20", alu_a, alu_b, alu_op);
        end
        checks++;
        if ((leds !== 8'h08) || (busy !== 1'b0)) begin
            failures++;
            $display("FAIL frame_leds got leds=%h busy=%b expected 08 0", leds, busy);
        end
    endtask

    task automatic test_tx_backpressure();
        bit stable;
        stable  = 1'b1;
        tx_full = 1'b1;
        #1;
        clear_logs();
        push_frame(8'h05, 8'h03, 8'h20);
        for (int i = 0; i < 14; i++) begin
            if ((i >= 4) && (w_data !== 8'h08)) stable = 1'b0;
            tick();
        end
        checks++;
        if (!stable || (n_push != 0)) begin
            failures++;
            $display("FAIL backpressure_hold got stable=%b pushes=%0d expected 1 0", stable, n_push);
        end
        tx_full = 1'b0;
        #1;
        run(4);
        checks++;
        if (push_mask !== 64'h4000) begin
            failures++;
            $display("FAIL backpressure_release got pushes=%h expected 4000", push_mask);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        push_byte(8'h0A);
        run(3);
        RESET = 1'b1;
        #1;
        push_frame(8'h01, 8'h02, 8'h20);
        tick();
        checks++;
        if ({rd_uart, busy, alu_a, w_data, leds} !== '0 || (pop_mask !== 64'h1)) begin
            failures++;
            $display("FAIL reset_mid_frame got rd=%b busy=%b a=%h w=%h leds=%h pops=%h expected all 0, pops 1",
                     rd_uart, busy, alu_a, w_data, leds, pop_mask);
        end
        RESET = 1'b0;
        #1;
        clear_logs();
        run(8);
        checks++;
        if ((pop_mask !== 64'h7) || (push_mask !== 64'h10) || ({alu_a, alu_b} !== 16'h0102) || (leds !== 8'h03)) begin
            failures++;
            $display("FAIL post_reset_frame got pops=%h pushes=%h a=%h b=%h leds=%h expected 7 10 01 02 03",
                     pop_mask, push_mask, alu_a, alu_b, leds);
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        push_frame(8'h05, 8'h03, 8'h20);
        push_frame(8'hFF, 8'h01, 8'h20);
        run(14);
        checks++;
        if ((pop_mask !== 64'hE7) || (push_mask !== 64'h210)) begin
            failures++;
            $display("FAIL back_to_back_timing got pops=%h pushes=%h expected e7 210", pop_mask, push_mask);
        end
        checks++;
        if ((n_push != 2) || (leds !== 8'h00)) begin
            failures++;
            $display("FAIL back_to_back_result got pushes=%0d leds=%h expected 2 00", n_push, leds);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[6];
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        int         k;
        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
        clear_logs();
        rand_tx = 1'b1;
        for (int f = 0; f < 24; f++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            k  = $urandom_range(0, 5);
            op = {2'($urandom_range(0, 3)), ops[k]};
            exp_q.push_back(alu_model(a, b, ops[k]));
            run($urandom_range(0, 4));
            push_byte(a);
            run($urandom_range(0, 4));
            push_byte(b);
            run($urandom_range(0, 4));
            push_byte(op);
        end
        wait_drain(600);
        rand_tx = 1'b0;
        tx_full = 1'b0;
        #1;
        checks++;
        if (n_push != 24) begin
            failures++;
            $display("FAIL random_count got %0d pushes expected 24", n_push);
        end
    endtask

`ifdef UART_ALU_TIMEOUT_EN
    task automatic test_timeout();
        err_allowed = 1'b1;
        clear_logs();
        push_byte(8'h11);
        run(20);
        err_allowed = 1'b0;
        checks++;
        if ((pop_mask !== 64'h1) || (err_mask !== 64'h10000)) begin
            failures++;
            $display("FAIL timeout_pulse got pops=%h errs=%h expected 1 10000", pop_mask, err_mask);
        end
        checks++;
        if ((busy !== 1'b0) || (alu_a !== 8'h11) || (n_push != 0)) begin
            failures++;
            $display("FAIL timeout_abort got busy=%b a=%h pushes=%0d expected 0 11 0", busy, alu_a, n_push);
        end
        // A byte landing on the last counted cycle must still be accepted.
        clear_logs();
        push_byte(8'h21);
        run(16);
        exp_q.push_back(alu_model(8'h21, 8'h03, 6'h20));
        push_byte(8'h03);
        push_byte(8'h20);
        run(8);
        checks++;
        if ((err_mask !== 64'h0) || (pop_mask !== 64'h30001) || (n_push != 1)) begin
            failures++;
            $display("FAIL timeout_boundary got errs=%h pops=%h pushes=%0d expected 0 30001 1",
                     err_mask, pop_mask, n_push);
        end
        clear_logs();
        push_frame(8'h02, 8'h02, 8'h20);
        run(8);
        checks++;
        if ((n_push != 1) || (leds !== 8'h04)) begin
            failures++;
            $display("FAIL timeout_recovery got pushes=%0d leds=%h expected 1 04", n_push, leds);
        end
    endtask
`else
    task automatic test_no_timeout();
        clear_logs();
        push_byte(8'h11);
        run(40);
        checks++;
        if ((busy !== 1'b1) || (err_mask !== 64'h0)) begin
            failures++;
            $display("FAIL wait_forever got busy=%b errs=%h expected 1 0", busy, err_mask);
        end
        exp_q.push_back(alu_model(8'h11, 8'h02, 6'h22));
        push_byte(8'h02);
        push_byte(8'h22);
        run(8);
        checks++;
        if ((n_push != 1) || (leds !== 8'h0F)) begin
            failures++;
            $display("FAIL late_frame got pushes=%0d leds=%h expected 1 0f", n_push, leds);
        end
    endtask
`endif

    // ---------------- main sequence and report ----------------
    initial begin
        RESET    = 1'b1;
        tx_full  = 1'b0;
        rx_empty = 1'b1;
        r_data   = 8'h00;
        test_reset();
        test_single_frame();
        test_tx_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
`ifdef UART_ALU_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_results got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog got no completion within time limit expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
